// File: rtl/stopwatch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_timer
//  Description : Single-clock stopwatch / countdown timer. It contains
//                enable-pulse prescalers, debounced pause and clear buttons,
//                field adjust with blinking, and a 4-digit multiplexed,
//                active-low seven-segment driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_timer #(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1,
    parameter int ADJ_HZ          = 2,
    parameter int SCAN_HZ         = 800,
    parameter int BLINK_HZ        = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int MIN_MAX         = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_pause,
    input  logic        btn_clear,
    input  logic        sw_sel,
    input  logic        sw_adj,
    input  logic        sw_dir,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_tick_div  = CLK_HZ / TICK_HZ;
    localparam int c_adj_div   = CLK_HZ / ADJ_HZ;
    localparam int c_scan_div  = CLK_HZ / SCAN_HZ;
    localparam int c_blink_div = CLK_HZ / BLINK_HZ;

    localparam int c_tick_w  = (c_tick_div  > 1) ? $clog2(c_tick_div)  : 1;
    localparam int c_adj_w   = (c_adj_div   > 1) ? $clog2(c_adj_div)   : 1;
    localparam int c_scan_w  = (c_scan_div  > 1) ? $clog2(c_scan_div)  : 1;
    localparam int c_blink_w = (c_blink_div > 1) ? $clog2(c_blink_div) : 1;
    localparam int c_deb_w   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(c_tick_div - 1);
    localparam logic [c_adj_w-1:0]   c_adj_last   = c_adj_w'(c_adj_div - 1);
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(c_scan_div - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(c_blink_div - 1);
    localparam logic [c_deb_w-1:0]   c_deb_full   = c_deb_w'(DEBOUNCE_CYCLES);
    localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEBOUNCE_CYCLES - 1);

    // Terminal value when counting up: MIN_MAX:59
    localparam logic [3:0]  c_max_m10 = 4'(MIN_MAX / 10);
    localparam logic [3:0]  c_max_m1  = 4'(MIN_MAX % 10);
    localparam logic [7:0]  c_max_min = {c_max_m10, c_max_m1};
    localparam logic [15:0] c_max_val = {c_max_m10, c_max_m1, 8'h59};

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t r_state, w_state_nxt;

    logic [3:0] r_min10, r_min1, r_sec10, r_sec1;
    logic [3:0] w_min10_nxt, w_min1_nxt, w_sec10_nxt, w_sec1_nxt;
    logic [3:0] w_up_m10, w_up_m1, w_up_s10, w_up_s1;
    logic [3:0] w_dn_m10, w_dn_m1, w_dn_s10, w_dn_s1;
    logic [15:0] w_cur_val;

    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_adj_w-1:0]   r_adj_cnt;
    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 w_tick, w_adj, w_scan, w_blink;
    logic                 r_blink_phase;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;
    logic       w_pause_press, w_clear_press;
    logic       w_run_entry, w_expire;

    logic [1:0] r_scan_idx;
    logic [3:0] r_an, w_an_code;
    logic [7:0] r_seg, w_seg_code;
    logic [3:0] w_cur_digit;
    logic       w_blank;
    logic       r_running, r_expired;

    // ------------------------------------------------------------------
    // Seven-segment code for one BCD digit, dp off
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler enable pulses (combinational decode of the wrap value)
    // ------------------------------------------------------------------
    assign w_tick  = (r_tick_cnt  == c_tick_last);
    assign w_adj   = (r_adj_cnt   == c_adj_last);
    assign w_scan  = (r_scan_cnt  == c_scan_last);
    assign w_blink = (r_blink_cnt == c_blink_last);

    // Tick prescaler restarts on RUN entry and on clear so a run always begins with a full tick period
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_clear_press || w_run_entry || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Free-running adjust-rate prescaler
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_adj_cnt <= '0;
        end else if (w_adj) begin
            r_adj_cnt <= '0;
        end else begin
            r_adj_cnt <= r_adj_cnt + 1'b1;
        end
    end

    // Free-running display-scan prescaler
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_cnt <= '0;
        end else if (w_scan) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Free-running blink prescaler; the phase flips on every wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button debouncers: index 0 = pause, index 1 = clear
    // ------------------------------------------------------------------
    assign w_btn_raw = {btn_clear, btn_pause};

    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
        logic [1:0]         r_sync;
        logic [c_deb_w-1:0] r_cnt;

        // Synchronise the raw pin, then count stable-high cycles up to saturation
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[0], w_btn_raw[gi]};
                if (!r_sync[1]) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_deb_full) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Single pulse per press: the count passes DEBOUNCE_CYCLES-1 only once per hold
        assign w_press[gi] = r_sync[1] && (r_cnt == c_deb_last);
    end

    assign w_pause_press = w_press[0];
    assign w_clear_press = w_press[1];

    // ------------------------------------------------------------------
    // BCD increment / decrement candidates for the running count
    // ------------------------------------------------------------------
    assign w_cur_val = {r_min10, r_min1, r_sec10, r_sec1};

    // Up count with carries sec1 -> sec10 -> min1 -> min10
    always_comb begin
        w_up_m10 = r_min10;
        w_up_m1  = r_min1;
        w_up_s10 = r_sec10;
        w_up_s1  = r_sec1;
        if (r_sec1 != 4'd9) begin
            w_up_s1 = r_sec1 + 4'd1;
        end else begin
            w_up_s1 = 4'd0;
            if (r_sec10 != 4'd5) begin
                w_up_s10 = r_sec10 + 4'd1;
            end else begin
                w_up_s10 = 4'd0;
                if (r_min1 != 4'd9) begin
                    w_up_m1 = r_min1 + 4'd1;
                end else begin
                    w_up_m1  = 4'd0;
                    w_up_m10 = r_min10 + 4'd1;
                end
            end
        end
    end

    // Down count with matching borrows; only used when the value is non-zero
    always_comb begin
        w_dn_m10 = r_min10;
        w_dn_m1  = r_min1;
        w_dn_s10 = r_sec10;
        w_dn_s1  = r_sec1;
        if (r_sec1 != 4'd0) begin
            w_dn_s1 = r_sec1 - 4'd1;
        end else begin
            w_dn_s1 = 4'd9;
            if (r_sec10 != 4'd0) begin
                w_dn_s10 = r_sec10 - 4'd1;
            end else begin
                w_dn_s10 = 4'd5;
                if (r_min1 != 4'd0) begin
                    w_dn_m1 = r_min1 - 4'd1;
                end else begin
                    w_dn_m1  = 4'd9;
                    w_dn_m10 = r_min10 - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State and time registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_PAUSE;
            r_min10   <= 4'd0;
            r_min1    <= 4'd0;
            r_sec10   <= 4'd0;
            r_sec1    <= 4'd0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min10   <= w_min10_nxt;
            r_min1    <= w_min1_nxt;
            r_sec10   <= w_sec10_nxt;
            r_sec1    <= w_sec1_nxt;
            r_running <= (r_state == ST_RUN);
            r_expired <= w_expire;
        end
    end

    // Next state and next time value; clear > adjust-enter > adjust-exit > pause
    always_comb begin
        w_state_nxt = r_state;
        w_min10_nxt = r_min10;
        w_min1_nxt  = r_min1;
        w_sec10_nxt = r_sec10;
        w_sec1_nxt  = r_sec1;

        if (w_clear_press) begin
            w_state_nxt = ST_PAUSE;
            w_min10_nxt = 4'd0;
            w_min1_nxt  = 4'd0;
            w_sec10_nxt = 4'd0;
            w_sec1_nxt  = 4'd0;
        end else if (sw_adj) begin
            w_state_nxt = ST_ADJUST;
            if ((r_state == ST_ADJUST) && w_adj) begin
                if (sw_sel) begin
                    // Minutes field, wraps past MIN_MAX without touching seconds
                    if ({r_min10, r_min1} >= c_max_min) begin
                        w_min10_nxt = 4'd0;
                        w_min1_nxt  = 4'd0;
                    end else if (r_min1 == 4'd9) begin
                        w_min1_nxt  = 4'd0;
                        w_min10_nxt = r_min10 + 4'd1;
                    end else begin
                        w_min1_nxt  = r_min1 + 4'd1;
                    end
                end else begin
                    // Seconds field, wraps past 59 without touching minutes
                    if ({r_sec10, r_sec1} >= 8'h59) begin
                        w_sec10_nxt = 4'd0;
                        w_sec1_nxt  = 4'd0;
                    end else if (r_sec1 == 4'd9) begin
                        w_sec1_nxt  = 4'd0;
                        w_sec10_nxt = r_sec10 + 4'd1;
                    end else begin
                        w_sec1_nxt  = r_sec1 + 4'd1;
                    end
                end
            end
        end else if (r_state == ST_ADJUST) begin
            w_state_nxt = ST_PAUSE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        if (!sw_dir) begin
                            if (w_cur_val == c_max_val) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_min10_nxt = w_up_m10;
                                w_min1_nxt  = w_up_m1;
                                w_sec10_nxt = w_up_s10;
                                w_sec1_nxt  = w_up_s1;
                                if ({w_up_m10, w_up_m1, w_up_s10, w_up_s1} == c_max_val) begin
                                    w_state_nxt = ST_DONE;
                                end
                            end
                        end else begin
                            if (w_cur_val == 16'h0000) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_min10_nxt = w_dn_m10;
                                w_min1_nxt  = w_dn_m1;
                                w_sec10_nxt = w_dn_s10;
                                w_sec1_nxt  = w_dn_s1;
                                if ({w_dn_m10, w_dn_m1, w_dn_s10, w_dn_s1} == 16'h0000) begin
                                    w_state_nxt = ST_DONE;
                                end
                            end
                        end
                    end
                    // A pause landing on a tick still lets that tick count
                    if (w_pause_press) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_press) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (w_pause_press) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = ST_PAUSE;
                end
            endcase
        end
    end

    assign w_run_entry = (r_state != ST_RUN)  && (w_state_nxt == ST_RUN);
    assign w_expire    = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    // Digit, anode pattern and blanking for the current scan index
    always_comb begin
        w_cur_digit = r_min10;
        w_an_code   = 4'b0111;
        case (r_scan_idx)
            2'd0: begin w_cur_digit = r_min10; w_an_code = 4'b0111; end
            2'd1: begin w_cur_digit = r_min1;  w_an_code = 4'b1011; end
            2'd2: begin w_cur_digit = r_sec10; w_an_code = 4'b1101; end
            default: begin w_cur_digit = r_sec1; w_an_code = 4'b1110; end
        endcase

        w_blank = 1'b0;
        if (r_blink_phase) begin
            if (r_state == ST_DONE) begin
                w_blank = 1'b1;
            end else if (r_state == ST_ADJUST) begin
                w_blank = sw_sel ? (r_scan_idx < 2'd2) : (r_scan_idx >= 2'd2);
            end
        end

        // The colon is the decimal point of the min1 digit
        w_seg_code = {(r_scan_idx != 2'd1), seg_decode(w_cur_digit)[6:0]};
        if (w_blank) begin
            w_seg_code = 8'hFF;
        end
    end

    // Latch the current digit onto the pins at each scan pulse, then advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scan_idx <= 2'd0;
            r_an       <= 4'b1111;
            r_seg      <= 8'hFF;
        end else if (w_scan) begin
            r_an       <= w_an_code;
            r_seg      <= w_seg_code;
            r_scan_idx <= r_scan_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign an      = r_an;
    assign seg     = r_seg;
    assign digits  = {r_min10, r_min1, r_sec10, r_sec1};
    assign running = r_running;
    assign expired = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_timer
//  Description : Directed self-checking bench for stopwatch_timer using
//                small rates (1 kHz clock, 10 Hz tick).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_pause, btn_clear;
    logic        sw_sel, sw_adj, sw_dir;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic        running, expired;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_timer #(
        .CLK_HZ          (1000),
        .TICK_HZ         (10),
        .ADJ_HZ          (20),
        .SCAN_HZ         (200),
        .BLINK_HZ        (50),
        .DEBOUNCE_CYCLES (4),
        .MIN_MAX         (59)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .sw_sel    (sw_sel),
        .sw_adj    (sw_adj),
        .sw_dir    (sw_dir),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .running   (running),
        .expired   (expired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait (bounded) for the displayed value to change
    task automatic wait_change(input string tag, input int max_cyc);
        logic [15:0] prev;
        int n;
        prev = digits;
        n = 0;
        while ((digits === prev) && (n < max_cyc)) begin
            step(1);
            n++;
        end
        check({tag, "_changed"}, 32'(digits !== prev), 32'd1);
    endtask

    task automatic wait_changes(input string tag, input int count);
        for (int i = 0; i < count; i++) wait_change(tag, 120);
    endtask

    task automatic wait_expired(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((expired !== 1'b1) && (n < max_cyc)) begin
            step(1);
            n++;
        end
        check(tag, 32'(expired), 32'd1);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        step(8);
        btn_pause = 1'b0;
        step(4);
    endtask

    initial begin
        int n_seen;
        int n;
        int min_blank, min_lit, sec_blank;
        int any_blank, any_lit;
        logic [7:0] min1_code;

        rst = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0;
        sw_sel = 1'b0; sw_adj = 1'b0; sw_dir = 1'b0;

        // ---------------- reset state ----------------
        step(2);
        check("rst_digits",  32'(digits),  32'h0000);
        check("rst_running", 32'(running), 32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        check("rst_an",      32'(an),      32'hF);
        check("rst_seg",     32'(seg),     32'hFF);
        rst = 1'b1;

        n = 0;
        while ((an === 4'b1111) && (n < 10)) begin step(1); n++; end
        check("first_scan_an",  32'(an),  32'b0111);
        check("first_scan_seg", 32'(seg), 32'hC0);

        // ---------------- start counting up ----------------
        btn_pause = 1'b1;
        n_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if ((running === 1'b1) && (n_seen == 0)) n_seen = i;
        end
        btn_pause = 1'b0;
        check("run_latency_6to8", 32'((n_seen >= 6) && (n_seen <= 8)), 32'd1);
        check("run_held_no_repeat", 32'(running), 32'd1);
        step(100 - (10 - n_seen));
        check("up_first_tick", 32'(digits), 32'h0001);
        step(600);
        check("up_seventh_tick", 32'(digits), 32'h0007);

        // 3-cycle glitch on pause: no press
        btn_pause = 1'b1;
        step(3);
        btn_pause = 1'b0;
        step(10);
        check("glitch_ignored", 32'(running), 32'd1);

        // plain clear
        btn_clear = 1'b1;
        step(8);
        btn_clear = 1'b0;
        step(4);
        check("clear_digits",  32'(digits),  32'h0000);
        check("clear_running", 32'(running), 32'd0);

        // ---------------- adjust to 58:58 ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        wait_changes("adj_sec", 58);
        check("adj_sec_58", 32'(digits), 32'h0058);
        sw_sel = 1'b1;
        wait_changes("adj_min", 58);
        check("adj_min_58", 32'(digits), 32'h5858);

        // minutes blink, seconds stay lit
        min_blank = 0; min_lit = 0; sec_blank = 0;
        for (int i = 0; i < 44; i++) begin
            step(1);
            if (an === 4'b0111) begin
                if (seg === 8'hFF) min_blank++;
                else if (seg === 8'h92) min_lit++;
            end
            if ((an === 4'b1110) && (seg === 8'hFF)) sec_blank++;
        end
        check("adj_min_blanked", 32'(min_blank > 0), 32'd1);
        check("adj_min_lit",     32'(min_lit > 0),   32'd1);
        check("adj_sec_never_blank", 32'(sec_blank), 32'd0);

        wait_changes("adj_min59", 1);
        check("adj_min_59", 32'(digits), 32'h5958);

        // ---------------- run up to the limit ----------------
        sw_adj = 1'b0;
        step(2);
        check("adj_exit_not_running", 32'(running), 32'd0);
        sw_dir = 1'b0;
        press_pause();
        wait_expired("up_expired", 250);
        check("up_limit_value", 32'(digits), 32'h5959);
        step(1);
        check("up_expired_one_cycle", 32'(expired), 32'd0);
        check("done_not_running", 32'(running), 32'd0);

        any_blank = 0; any_lit = 0; min1_code = 8'h00;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (seg === 8'hFF) any_blank++;
            else begin
                any_lit++;
                if (an === 4'b1011) min1_code = seg;
            end
        end
        check("done_blank_seen", 32'(any_blank > 0), 32'd1);
        check("done_lit_seen",   32'(any_lit > 0),   32'd1);
        check("done_min1_colon_code", 32'(min1_code), 32'h10);
        step(150);
        check("done_value_held", 32'(digits), 32'h5959);

        // ---------------- field wrap without carry ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        wait_changes("wrap_min", 1);
        check("wrap_min_to_00", 32'(digits), 32'h0059);
        sw_sel = 1'b0;
        wait_changes("wrap_sec", 1);
        check("wrap_sec_to_00", 32'(digits), 32'h0000);

        // ---------------- count down from 01:01 ----------------
        sw_sel = 1'b1;
        wait_changes("set_0100", 1);
        sw_sel = 1'b0;
        wait_changes("set_0101", 1);
        check("set_0101", 32'(digits), 32'h0101);
        sw_adj = 1'b0;
        step(2);
        sw_dir = 1'b1;
        press_pause();
        wait_change("down1", 150);
        check("down_0100", 32'(digits), 32'h0100);
        wait_change("down2", 150);
        check("down_0059", 32'(digits), 32'h0059);
        wait_expired("down_expired", 6200);
        check("down_zero", 32'(digits), 32'h0000);
        step(150);
        check("down_zero_held", 32'(digits), 32'h0000);

        // run from 00:00 counting down: DONE on first tick, value unchanged
        press_pause();
        check("done_to_pause", 32'(running), 32'd0);
        press_pause();
        check("zero_run_entered", 32'(running), 32'd1);
        wait_expired("zero_run_expired", 200);
        check("zero_run_value", 32'(digits), 32'h0000);

        // ---------------- clear coincident with tick at 12:34 ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        wait_changes("set_min12", 12);
        check("set_1200", 32'(digits), 32'h1200);
        sw_sel = 1'b0;
        wait_changes("set_sec33", 33);
        check("set_1233", 32'(digits), 32'h1233);
        sw_adj = 1'b0;
        step(2);
        sw_dir = 1'b0;
        press_pause();
        wait_change("to_1234", 150);
        check("at_1234", 32'(digits), 32'h1234);
        step(94);
        btn_clear = 1'b1;
        step(6);
        check("clear_beats_tick", 32'(digits), 32'h0000);
        step(2);
        btn_clear = 1'b0;
        step(4);
        check("clear_tick_running", 32'(running), 32'd0);
        step(120);
        check("clear_tick_paused", 32'(digits), 32'h0000);

        // ---------------- reset mid-run at 05:05 ----------------
        sw_adj = 1'b1;
        sw_sel = 1'b1;
        wait_changes("set_min5", 5);
        sw_sel = 1'b0;
        wait_changes("set_sec5", 5);
        check("set_0505", 32'(digits), 32'h0505);
        sw_adj = 1'b0;
        step(2);
        press_pause();
        step(30);
        check("pre_rst_running", 32'(running), 32'd1);
        rst = 1'b0;
        step(1);
        check("mid_rst_digits",  32'(digits),  32'h0000);
        check("mid_rst_an",      32'(an),      32'hF);
        check("mid_rst_seg",     32'(seg),     32'hFF);
        check("mid_rst_running", 32'(running), 32'd0);
        rst = 1'b1;
        step(200);
        check("post_rst_paused", 32'(digits), 32'h0000);
        check("post_rst_not_running", 32'(running), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
